// File: rtl/inst_queue_pkg.sv
// Shared frontend/backend types for the instruction queue.
// IQ_DEPTH lives here so fetch and issue agree on queue sizing.
package inst_queue_pkg;

    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } inst_t;

endpackage

// File: rtl/inst_queue.sv
// Two-wide in-order instruction FIFO between fetch and backend issue.
// Accepts 0..2 fetched instructions per cycle and retires 0..2 per cycle.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  inst_t [1:0]     fetch_inst_i,
    input  logic  [1:0]     fetch_valid_i,
    output logic            fetch_ready_o,
    output inst_t [1:0]     inst_o,
    output logic  [1:0]     inst_valid_o,
    input  logic  [1:0]     issue_num_i,
    input  logic            backend_stall_i
);

    inst_t              r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic [PTR_W-1:0]   w_head_p1;
    logic [PTR_W-1:0]   w_tail_p1;
    logic [1:0]         w_issue;
    logic [1:0]         w_deq;
    logic [1:0]         w_enq;
    inst_t              w_wr0;

    assign w_head_p1 = r_head + PTR_W'(1);
    assign w_tail_p1 = r_tail + PTR_W'(1);

    assign inst_o[0]       = r_mem[r_head];
    assign inst_o[1]       = r_mem[w_head_p1];
    assign inst_valid_o[0] = (r_count != '0);
    assign inst_valid_o[1] = (r_count >= CNT_W'(2));

    // Ready is taken from registered count only, so there is no comb path from the backend.
    assign fetch_ready_o = (r_count <= CNT_W'(DEPTH - 2));

    always_comb begin
        w_issue = (issue_num_i == 2'd3) ? 2'd2 : issue_num_i;
        w_deq   = 2'd0;
        if (!backend_stall_i) begin
            if (r_count < CNT_W'(w_issue))
                w_deq = r_count[1:0];
            else
                w_deq = w_issue;
        end
    end

    // Compaction: a lone valid slot 1 lands at tail just like a lone slot 0.
    always_comb begin
        w_enq = 2'd0;
        if (fetch_ready_o)
            w_enq = {1'b0, fetch_valid_i[0]} + {1'b0, fetch_valid_i[1]};
        w_wr0 = fetch_valid_i[0] ? fetch_inst_i[0] : fetch_inst_i[1];
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_deq);
            r_tail  <= r_tail + PTR_W'(w_enq);
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i && w_enq != 2'd0) begin
            r_mem[r_tail] <= w_wr0;
            if (w_enq == 2'd2)
                r_mem[w_tail_p1] <= fetch_inst_i[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_count <= CNT_W'(DEPTH))
                else $error("inst_queue: count out of range %0d", r_count);
            if (!flush_i && !fetch_ready_o && fetch_valid_i != 2'b00)
                $warning("inst_queue: dropped fetch, valid=%b", fetch_valid_i);
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, enqueue/dequeue, full, clamp, wrap, flush.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic         clk;
    logic         rst;
    logic         flush_i;
    inst_t [1:0]  fetch_inst_i;
    logic  [1:0]  fetch_valid_i;
    logic         fetch_ready_o;
    inst_t [1:0]  inst_o;
    logic  [1:0]  inst_valid_o;
    logic  [1:0]  issue_num_i;
    logic         backend_stall_i;

    int checks = 0;
    int failures = 0;

    inst_queue #(.DEPTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .fetch_inst_i    (fetch_inst_i),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_ready_o   (fetch_ready_o),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o),
        .issue_num_i     (issue_num_i),
        .backend_stall_i (backend_stall_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic inst_t mk(input int n);
        inst_t t;
        t.pc   = 32'h1000 + 32'(n) * 4;
        t.insn = 32'hA000_0000 + 32'(n);
        return t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 0; flush_i = 0; fetch_valid_i = 2'b00;
        fetch_inst_i[0] = '0; fetch_inst_i[1] = '0;
        issue_num_i = 2'd0; backend_stall_i = 0;
    endtask

    // Apply current inputs across one rising edge, return 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push(input logic [1:0] v, input int a, input int b);
        fetch_valid_i = v;
        fetch_inst_i[0] = mk(a);
        fetch_inst_i[1] = mk(b);
    endtask

    inst_t q[$];
    int n;

    initial begin
        idle();
        rst = 1;
        step();
        step();
        chk("reset_valid", 64'(inst_valid_o), 64'b00);
        chk("reset_ready", 64'(fetch_ready_o), 64'd1);
        chk("reset_count", 64'(dut.r_count), 64'd0);

        // A,B then C
        push(2'b11, 1, 2); step();
        chk("ab_slot0", inst_o[0], mk(1));
        chk("ab_slot1", inst_o[1], mk(2));
        chk("ab_valid", 64'(inst_valid_o), 64'b11);
        push(2'b01, 3, 0); step();
        chk("abc_count", 64'(dut.r_count), 64'd3);
        issue_num_i = 2'd1; step();
        chk("iss1_slot0", inst_o[0], mk(2));
        chk("iss1_slot1", inst_o[1], mk(3));
        issue_num_i = 2'd2; backend_stall_i = 1; step();
        chk("stall_slot0", inst_o[0], mk(2));
        chk("stall_slot1", inst_o[1], mk(3));
        chk("stall_count", 64'(dut.r_count), 64'd2);

        // Fill to 7
        flush_i = 1; step();
        chk("flush_empty", 64'(inst_valid_o), 64'b00);
        push(2'b11, 10, 11); step();
        push(2'b11, 12, 13); step();
        push(2'b11, 14, 15); step();
        chk("six_ready", 64'(fetch_ready_o), 64'd1);
        push(2'b01, 16, 0); step();
        chk("full7_count", 64'(dut.r_count), 64'd7);
        chk("full7_ready", 64'(fetch_ready_o), 64'd0);
        push(2'b11, 90, 91); step();
        chk("drop_count", 64'(dut.r_count), 64'd7);
        chk("drop_head", inst_o[0], mk(10));
        issue_num_i = 2'd2; step();
        chk("drain_count", 64'(dut.r_count), 64'd5);
        chk("drain_ready", 64'(fetch_ready_o), 64'd1);
        chk("drain_head", inst_o[0], mk(12));
        chk("drain_slot1", inst_o[1], mk(13));

        // Compaction and over-issue clamp
        flush_i = 1; step();
        push(2'b10, 77, 20); step();
        chk("cmp_slot0", inst_o[0], mk(20));
        chk("cmp_valid", 64'(inst_valid_o), 64'b01);
        chk("cmp_count", 64'(dut.r_count), 64'd1);
        issue_num_i = 2'd2; step();
        chk("clamp_count", 64'(dut.r_count), 64'd0);
        chk("clamp_valid", 64'(inst_valid_o), 64'b00);
        push(2'b11, 21, 22); step();
        push(2'b01, 23, 0); step();
        issue_num_i = 2'd3; step();
        chk("iss3_count", 64'(dut.r_count), 64'd1);
        chk("iss3_head", inst_o[0], mk(23));
        issue_num_i = 2'd2; step();
        chk("iss_empty_count", 64'(dut.r_count), 64'd0);

        // Streaming 2-in/2-out through several pointer wraps
        flush_i = 1; step();
        q.delete();
        push(2'b11, 100, 101); step();
        q.push_back(mk(100)); q.push_back(mk(101));
        n = 102;
        for (int c = 0; c < 20; c++) begin
            push(2'b11, n, n + 1);
            issue_num_i = 2'd2;
            step();
            q.push_back(mk(n)); q.push_back(mk(n + 1));
            void'(q.pop_front()); void'(q.pop_front());
            n += 2;
            chk($sformatf("strm%0d_s0", c), inst_o[0], q[0]);
            chk($sformatf("strm%0d_s1", c), inst_o[1], q[1]);
            chk($sformatf("strm%0d_cnt", c), 64'(dut.r_count), 64'd2);
        end

        // Flush beats simultaneous push and issue
        flush_i = 1; step();
        push(2'b11, 30, 31); step();
        push(2'b11, 32, 33); step();
        push(2'b01, 34, 0); step();
        chk("pre_flush_count", 64'(dut.r_count), 64'd5);
        flush_i = 1; push(2'b11, 40, 41); issue_num_i = 2'd2; step();
        chk("flush_count", 64'(dut.r_count), 64'd0);
        chk("flush_valid", 64'(inst_valid_o), 64'b00);
        chk("flush_ready", 64'(fetch_ready_o), 64'd1);

        // Reset mid-stream
        push(2'b11, 50, 51); step();
        push(2'b11, 52, 53); issue_num_i = 2'd1; step();
        chk("mid_count", 64'(dut.r_count), 64'd3);
        rst = 1; push(2'b11, 54, 55); issue_num_i = 2'd1; step();
        chk("rst_count", 64'(dut.r_count), 64'd0);
        chk("rst_valid", 64'(inst_valid_o), 64'b00);
        chk("rst_ready", 64'(fetch_ready_o), 64'd1);
        push(2'b01, 60, 0); step();
        chk("post_rst_head", inst_o[0], mk(60));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
